mem_bank_arbiter: RTL and testbench
===================================

# mem_bank_arbiter

Per-bank request arbiter and response router for the memory island, generalised to a parametric number of narrow requestors plus one wide requestor. It sits directly in front of one SRAM macro. It grants at most one access per cycle, using round-robin between narrow ports and time-bounded narrow priority over the wide port (`WidePriorityWait`). It routes bank read data back to the originator after a fixed `BankAccessLatency`.

## Interface
Parameters:
- `NumNarrowReq`, 4: narrow requestors, 1..32.
- `AddrWidth`, 10: bank word address width.
- `DataWidth`, 32: bank word width; multiple of 8.
- `WidePriorityWait`, 4: wide-wait cycles before the wide port takes priority; 0 = narrow always wins.
- `BankAccessLatency`, 1: grant-to-response cycles, 1..4.
- `CntWidth`, 16: stall counter width.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  synchronous, active-low reset.
- `narrow_req_i`  in  NumNarrowReq  request per narrow port.
- `narrow_gnt_o`  out  NumNarrowReq  grant; one-hot or zero.
- `narrow_addr_i`  in  NumNarrowReq*AddrWidth  packed addresses.
- `narrow_we_i`  in  NumNarrowReq  write enable.
- `narrow_wdata_i`  in  NumNarrowReq*DataWidth  write data.
- `narrow_be_i`  in  NumNarrowReq*DataWidth/8  byte enables.
- `narrow_rvalid_o`  out  NumNarrowReq  response valid per port.
- `narrow_rdata_o`  out  DataWidth  shared read data, qualified by `narrow_rvalid_o`.
- `wide_req_i`, `wide_we_i`  in  1 each.
- `wide_gnt_o`, `wide_rvalid_o`  out  1 each.
- `wide_addr_i`  in  AddrWidth.
- `wide_wdata_i`  in  DataWidth.
- `wide_be_i`  in  DataWidth/8.
- `wide_rdata_o`  out  DataWidth.
- `bank_req_o`, `bank_we_o`  out  1 each  to the macro.
- `bank_addr_o`  out  AddrWidth.
- `bank_wdata_o`  out  DataWidth.
- `bank_be_o`  out  DataWidth/8.
- `bank_rdata_i`  in  DataWidth  valid `BankAccessLatency` cycles after `bank_req_o`.
- `stall_cnt_o`  out  CntWidth  see Configuration.

## Operation
- Transfer: `req & gnt` in the same cycle. A requestor holds `req` and payload stable until granted.
- Narrow arbitration is round-robin. Search starts at `rr_ptr+1` modulo `NumNarrowReq`. `rr_ptr` updates to the granted index on a narrow grant. Reset value is `NumNarrowReq-1`, so port 0 wins first.
- Priority modes:
  - NARROW (default): any narrow request wins over the wide port.
  - WIDE: entered when `wait_cnt == WidePriorityWait` and `WidePriorityWait != 0`. The wide port wins that cycle if it requests.
- `wait_cnt` (width clog2(WidePriorityWait+1)):
  - increments when `wide_req_i & !wide_gnt_o`, saturating;
  - clears on a wide grant or when `wide_req_i` is low.
- With no narrow requests, the wide request is granted immediately regardless of `wait_cnt`.
- Bank outputs mux the winner's payload; `bank_req_o` = any grant. With no grant, payload outputs are don't-care and `bank_req_o` = 0.
- Response pipeline: `BankAccessLatency` stages, each holding {valid, is_wide, narrow index}. The entry is pushed on every grant, reads and writes alike.
- At the tail, the matching `*_rvalid_o` pulses for one cycle. This is a write acknowledge for writes. `narrow_rdata_o` and `wide_rdata_o` both equal `bank_rdata_i`.
- Reset mid-operation: in-flight pipeline entries are discarded (no rvalid). `wait_cnt` = 0, `rr_ptr` = `NumNarrowReq-1`.

## Timing
- Grants and bank outputs are combinational from requests; arbitration state is registered.
- Throughput is one access per cycle; back-to-back grants to the same port are allowed.
- Response latency is exactly `BankAccessLatency` cycles from the grant edge.
- Outputs held in reset: all `*_gnt_o` follow requests (combinational), all `*_rvalid_o` = 0, `stall_cnt_o` = 0.
- Worst-case wide wait: `WidePriorityWait` cycles plus the grant cycle.
- Worst-case narrow wait: `NumNarrowReq-1` narrow grants plus the interleaved wide grants.

## Configuration
- `LAGD_MEM_ARB_STALL_CNT_EN` defined: `stall_cnt_o` counts cycles in which any requestor has `req` high without `gnt`. The counter saturates at all-ones and clears on reset.
- Undefined: `stall_cnt_o` is tied to 0 and no counter flops are built.

## Test plan
- N=4, L=1: ports 0..3 request continuously. Grants go 0,1,2,3,0 on consecutive cycles; each `narrow_rvalid_o[i]` rises one cycle after its grant.
- Wide plus narrow 0 requesting continuously, WidePriorityWait=4: wide is granted on the 5th cycle, then narrow resumes. The pattern repeats every 5 cycles.
- WidePriorityWait=0, narrow 1 requesting always: wide is never granted. A stall count of 10 after 10 cycles is expected with the macro defined.
- L=3: read addr 0x12 from wide while the macro returns 0xDEADBEEF. `wide_rvalid_o` = 1 with that data exactly 3 cycles after the grant; no narrow rvalid.
- Reset asserted one cycle after a grant with L=3: no rvalid appears afterwards; the next grant goes to port 0.

Source files
------------

// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: single-bank request arbiter and response router.
// Round-robin among narrow ports, time-bounded narrow priority over the wide
// port, fixed-latency response routing back to the granted requestor.
// Optional feature: define LAGD_MEM_ARB_STALL_CNT_EN to build the stall counter.
module mem_bank_arbiter #(
  parameter int unsigned NumNarrowReq      = 4,
  parameter int unsigned AddrWidth         = 10,
  parameter int unsigned DataWidth         = 32,
  parameter int unsigned WidePriorityWait  = 4,
  parameter int unsigned BankAccessLatency = 1,
  parameter int unsigned CntWidth          = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumNarrowReq-1:0]               narrow_req_i,
  output logic [NumNarrowReq-1:0]               narrow_gnt_o,
  input  logic [NumNarrowReq*AddrWidth-1:0]     narrow_addr_i,
  input  logic [NumNarrowReq-1:0]               narrow_we_i,
  input  logic [NumNarrowReq*DataWidth-1:0]     narrow_wdata_i,
  input  logic [NumNarrowReq*DataWidth/8-1:0]   narrow_be_i,
  output logic [NumNarrowReq-1:0]               narrow_rvalid_o,
  output logic [DataWidth-1:0]                  narrow_rdata_o,
  input  logic                                  wide_req_i,
  input  logic                                  wide_we_i,
  output logic                                  wide_gnt_o,
  output logic                                  wide_rvalid_o,
  input  logic [AddrWidth-1:0]                  wide_addr_i,
  input  logic [DataWidth-1:0]                  wide_wdata_i,
  input  logic [DataWidth/8-1:0]                wide_be_i,
  output logic [DataWidth-1:0]                  wide_rdata_o,
  output logic                                  bank_req_o,
  output logic                                  bank_we_o,
  output logic [AddrWidth-1:0]                  bank_addr_o,
  output logic [DataWidth-1:0]                  bank_wdata_o,
  output logic [DataWidth/8-1:0]                bank_be_o,
  input  logic [DataWidth-1:0]                  bank_rdata_i,
  output logic [CntWidth-1:0]                   stall_cnt_o
);

  localparam int unsigned IdxWidth  = (NumNarrowReq > 1) ? $clog2(NumNarrowReq) : 1;
  localparam int unsigned WaitWidth = (WidePriorityWait > 0) ? $clog2(WidePriorityWait + 1) : 1;
  localparam int unsigned BeWidth   = DataWidth / 8;

  typedef enum logic {
    PRIO_NARROW,
    PRIO_WIDE
  } prio_e;

  typedef struct packed {
    logic                vld;
    logic                wide;
    logic [IdxWidth-1:0] idx;
  } rsp_t;

  prio_e                  prio_mode;
  logic [IdxWidth-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WaitWidth-1:0]   wait_cnt_q, wait_cnt_d;
  logic                   any_narrow;
  logic                   narrow_found;
  logic [IdxWidth-1:0]    narrow_sel;
  int unsigned            rr_cand;
  logic                   wide_gnt;
  logic [NumNarrowReq-1:0] narrow_gnt;
  rsp_t                   rsp_head_d;
  rsp_t                   pipe_q [BankAccessLatency];
  rsp_t                   rsp_tail;

  // Wide port takes priority once it has waited the full bound
  always_comb begin
    prio_mode = PRIO_NARROW;
    if ((WidePriorityWait != 0) && (wait_cnt_q == WaitWidth'(WidePriorityWait))) begin
      prio_mode = PRIO_WIDE;
    end
  end

  // Round-robin search starting one past the last narrow winner
  always_comb begin
    narrow_found = 1'b0;
    narrow_sel   = '0;
    rr_cand      = 0;
    for (int unsigned off = 1; off <= NumNarrowReq; off++) begin
      rr_cand = 32'(rr_ptr_q) + off;
      if (rr_cand >= NumNarrowReq) begin
        rr_cand = rr_cand - NumNarrowReq;
      end
      if (!narrow_found && narrow_req_i[rr_cand[IdxWidth-1:0]]) begin
        narrow_found = 1'b1;
        narrow_sel   = rr_cand[IdxWidth-1:0];
      end
    end
  end

  // Grant decision: wide wins when alone or in wide-priority mode
  always_comb begin
    any_narrow = |narrow_req_i;
    wide_gnt   = wide_req_i & (~any_narrow | (prio_mode == PRIO_WIDE));
    narrow_gnt = '0;
    if (!wide_gnt && narrow_found) begin
      narrow_gnt[narrow_sel] = 1'b1;
    end
  end

  assign narrow_gnt_o = narrow_gnt;
  assign wide_gnt_o   = wide_gnt;

  // Bank payload mux; defaults to the wide payload when no narrow grant
  always_comb begin
    bank_req_o   = wide_gnt | (|narrow_gnt);
    bank_we_o    = wide_we_i;
    bank_addr_o  = wide_addr_i;
    bank_wdata_o = wide_wdata_i;
    bank_be_o    = wide_be_i;
    for (int unsigned i = 0; i < NumNarrowReq; i++) begin
      if (narrow_gnt[i]) begin
        bank_we_o    = narrow_we_i[i];
        bank_addr_o  = narrow_addr_i[i*AddrWidth +: AddrWidth];
        bank_wdata_o = narrow_wdata_i[i*DataWidth +: DataWidth];
        bank_be_o    = narrow_be_i[i*BeWidth +: BeWidth];
      end
    end
  end

  // Arbitration next-state: pointer follows narrow winner, wait counter saturates
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (!wide_gnt && narrow_found) begin
      rr_ptr_d = narrow_sel;
    end
    wait_cnt_d = '0;
    if (wide_req_i && !wide_gnt) begin
      if (wait_cnt_q == WaitWidth'(WidePriorityWait)) begin
        wait_cnt_d = wait_cnt_q;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_ptr_q   <= IdxWidth'(NumNarrowReq - 1);
      wait_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Response pipeline head entry: one per grant, reads and writes alike
  always_comb begin
    rsp_head_d      = '0;
    rsp_head_d.vld  = bank_req_o;
    rsp_head_d.wide = wide_gnt;
    rsp_head_d.idx  = narrow_sel;
  end

  // Response pipeline shift register; reset drops in-flight entries
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < BankAccessLatency; s++) begin
        pipe_q[s] <= '0;
      end
    end else begin
      pipe_q[0] <= rsp_head_d;
      for (int unsigned s = 1; s < BankAccessLatency; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
    end
  end

  assign rsp_tail = pipe_q[BankAccessLatency-1];

  // Route the tail entry to its originator; suppressed while in reset
  always_comb begin
    narrow_rvalid_o = '0;
    wide_rvalid_o   = 1'b0;
    if (rst_ni && rsp_tail.vld) begin
      if (rsp_tail.wide) begin
        wide_rvalid_o = 1'b1;
      end else begin
        narrow_rvalid_o[rsp_tail.idx] = 1'b1;
      end
    end
  end

  assign narrow_rdata_o = bank_rdata_i;
  assign wide_rdata_o   = bank_rdata_i;

`ifdef LAGD_MEM_ARB_STALL_CNT_EN
  logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;
  logic                stall_any;

  // Count cycles where any requestor is left waiting, saturating
  always_comb begin
    stall_any   = (|(narrow_req_i & ~narrow_gnt)) | (wide_req_i & ~wide_gnt);
    stall_cnt_d = stall_cnt_q;
    if (stall_any && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = rst_ni ? stall_cnt_q : '0;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Bench for mem_bank_arbiter: vector table, directed corner sequences and a
// randomized run against a behavioural model of the arbitration rules.
module tb_mem_bank_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int CW = 16;
  localparam int WPW_A = 4;
  localparam int LAT_A = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance A: WidePriorityWait=4, latency 1
  logic            a_rst_n;
  logic [N-1:0]    a_nreq, a_ngnt, a_nwe, a_nrvalid;
  logic [N*AW-1:0] a_naddr;
  logic [N*DW-1:0] a_nwdata;
  logic [N*BW-1:0] a_nbe;
  logic [DW-1:0]   a_nrdata, a_wwdata, a_wrdata, a_bwdata, a_brdata;
  logic            a_wreq, a_wwe, a_wgnt, a_wrvalid, a_breq, a_bwe;
  logic [AW-1:0]   a_waddr, a_baddr;
  logic [BW-1:0]   a_wbe, a_bbe;
  logic [CW-1:0]   a_stall;

  // Instance B: WidePriorityWait=0, latency 3
  logic            b_rst_n;
  logic [N-1:0]    b_nreq, b_ngnt, b_nwe, b_nrvalid;
  logic [N*AW-1:0] b_naddr;
  logic [N*DW-1:0] b_nwdata;
  logic [N*BW-1:0] b_nbe;
  logic [DW-1:0]   b_nrdata, b_wwdata, b_wrdata, b_bwdata, b_brdata;
  logic            b_wreq, b_wwe, b_wgnt, b_wrvalid, b_breq, b_bwe;
  logic [AW-1:0]   b_waddr, b_baddr;
  logic [BW-1:0]   b_wbe, b_bbe;
  logic [CW-1:0]   b_stall;

  mem_bank_arbiter #(
    .NumNarrowReq(N), .AddrWidth(AW), .DataWidth(DW),
    .WidePriorityWait(WPW_A), .BankAccessLatency(LAT_A), .CntWidth(CW)
  ) u_a (
    .clk_i(clk), .rst_ni(a_rst_n),
    .narrow_req_i(a_nreq), .narrow_gnt_o(a_ngnt), .narrow_addr_i(a_naddr),
    .narrow_we_i(a_nwe), .narrow_wdata_i(a_nwdata), .narrow_be_i(a_nbe),
    .narrow_rvalid_o(a_nrvalid), .narrow_rdata_o(a_nrdata),
    .wide_req_i(a_wreq), .wide_we_i(a_wwe), .wide_gnt_o(a_wgnt), .wide_rvalid_o(a_wrvalid),
    .wide_addr_i(a_waddr), .wide_wdata_i(a_wwdata), .wide_be_i(a_wbe), .wide_rdata_o(a_wrdata),
    .bank_req_o(a_breq), .bank_we_o(a_bwe), .bank_addr_o(a_baddr), .bank_wdata_o(a_bwdata),
    .bank_be_o(a_bbe), .bank_rdata_i(a_brdata), .stall_cnt_o(a_stall)
  );

  mem_bank_arbiter #(
    .NumNarrowReq(N), .AddrWidth(AW), .DataWidth(DW),
    .WidePriorityWait(0), .BankAccessLatency(3), .CntWidth(CW)
  ) u_b (
    .clk_i(clk), .rst_ni(b_rst_n),
    .narrow_req_i(b_nreq), .narrow_gnt_o(b_ngnt), .narrow_addr_i(b_naddr),
    .narrow_we_i(b_nwe), .narrow_wdata_i(b_nwdata), .narrow_be_i(b_nbe),
    .narrow_rvalid_o(b_nrvalid), .narrow_rdata_o(b_nrdata),
    .wide_req_i(b_wreq), .wide_we_i(b_wwe), .wide_gnt_o(b_wgnt), .wide_rvalid_o(b_wrvalid),
    .wide_addr_i(b_waddr), .wide_wdata_i(b_wwdata), .wide_be_i(b_wbe), .wide_rdata_o(b_wrdata),
    .bank_req_o(b_breq), .bank_we_o(b_bwe), .bank_addr_o(b_baddr), .bank_wdata_o(b_bwdata),
    .bank_be_o(b_bbe), .bank_rdata_i(b_brdata), .stall_cnt_o(b_stall)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0] nreq;
    logic         wreq;
    logic [N-1:0] egn;
    logic         egw;
    logic [N-1:0] enrv;
    logic         ewrv;
  } vec_t;

  typedef struct {
    int due;
    bit wide;
    int idx;
  } rsp_t;

  vec_t tbl [20];

  // Behavioural model state for the randomized run on instance A
  int            m_rr, m_wait, cyc, exp_n;
  int unsigned   m_stall;
  bit            exp_w, stalled, any_n;
  bit            n_hold [N];
  bit            w_hold;
  logic [AW-1:0] m_addr [N];
  logic          m_we [N];
  logic [DW-1:0] m_wd [N];
  logic [BW-1:0] m_be [N];
  rsp_t          rq [$];
  logic [N-1:0]  exp_nrv;
  bit            exp_wrv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'hF, 1'b0, 4'h1, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{4'hF, 1'b0, 4'h2, 1'b0, 4'h1, 1'b0};
    tbl[2]  = '{4'hF, 1'b0, 4'h4, 1'b0, 4'h2, 1'b0};
    tbl[3]  = '{4'hF, 1'b0, 4'h8, 1'b0, 4'h4, 1'b0};
    tbl[4]  = '{4'hF, 1'b0, 4'h1, 1'b0, 4'h8, 1'b0};
    tbl[5]  = '{4'h1, 1'b1, 4'h1, 1'b0, 4'h1, 1'b0};
    tbl[6]  = '{4'h1, 1'b1, 4'h1, 1'b0, 4'h1, 1'b0};
    tbl[7]  = '{4'h1, 1'b1, 4'h1, 1'b0, 4'h1, 1'b0};
    tbl[8]  = '{4'h1, 1'b1, 4'h1, 1'b0, 4'h1, 1'b0};
    tbl[9]  = '{4'h1, 1'b1, 4'h0, 1'b1, 4'h1, 1'b0};
    tbl[10] = '{4'h1, 1'b1, 4'h1, 1'b0, 4'h0, 1'b1};
    tbl[11] = '{4'h1, 1'b1, 4'h1, 1'b0, 4'h1, 1'b0};
    tbl[12] = '{4'h1, 1'b1, 4'h1, 1'b0, 4'h1, 1'b0};
    tbl[13] = '{4'h1, 1'b1, 4'h1, 1'b0, 4'h1, 1'b0};
    tbl[14] = '{4'h1, 1'b1, 4'h0, 1'b1, 4'h1, 1'b0};
    tbl[15] = '{4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1};
    tbl[16] = '{4'h0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0};
    tbl[17] = '{4'h6, 1'b0, 4'h2, 1'b0, 4'h0, 1'b1};
    tbl[18] = '{4'h6, 1'b0, 4'h4, 1'b0, 4'h2, 1'b0};
    tbl[19] = '{4'h0, 1'b0, 4'h0, 1'b0, 4'h4, 1'b0};

    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_nreq = '0; a_nwe = '0; a_naddr = '0; a_nwdata = '0; a_nbe = '0;
    a_wreq = 1'b0; a_wwe = 1'b0; a_waddr = '0; a_wwdata = '0; a_wbe = '0; a_brdata = '0;
    b_nreq = '0; b_nwe = '0; b_naddr = '0; b_nwdata = '0; b_nbe = '0;
    b_wreq = 1'b0; b_wwe = 1'b0; b_waddr = '0; b_wwdata = '0; b_wbe = '0; b_brdata = '0;

    // Reset state: grants still follow requests, responses and stall held at 0
    repeat (2) @(posedge clk);
    #1 a_nreq = 4'hF;
    @(negedge clk);
    check("rst_ngnt", 32'(a_ngnt), 32'h1);
    check("rst_nrvalid", 32'(a_nrvalid), 32'h0);
    check("rst_wrvalid", 32'(a_wrvalid), 32'h0);
    check("rst_stall", 32'(a_stall), 32'h0);
    check("rst_b_stall", 32'(b_stall), 32'h0);
    @(posedge clk);
    #1 a_rst_n = 1'b1; b_rst_n = 1'b1; a_nreq = '0;

    // Vector table on instance A
    for (int i = 0; i < 20; i++) begin
      a_nreq = tbl[i].nreq;
      a_wreq = tbl[i].wreq;
      @(negedge clk);
      check($sformatf("tbl%0d_ngnt", i), 32'(a_ngnt), 32'(tbl[i].egn));
      check($sformatf("tbl%0d_wgnt", i), 32'(a_wgnt), 32'(tbl[i].egw));
      check($sformatf("tbl%0d_nrv", i), 32'(a_nrvalid), 32'(tbl[i].enrv));
      check($sformatf("tbl%0d_wrv", i), 32'(a_wrvalid), 32'(tbl[i].ewrv));
      check($sformatf("tbl%0d_breq", i), 32'(a_breq), 32'((tbl[i].egn != 0) || tbl[i].egw));
      @(posedge clk);
      #1;
    end
    a_nreq = '0; a_wreq = 1'b0;

    // B: WidePriorityWait=0, narrow 1 and wide both always requesting
    b_nreq = 4'b0010; b_wreq = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("b_starve%0d_ngnt", k), 32'(b_ngnt), 32'h2);
      check($sformatf("b_starve%0d_wgnt", k), 32'(b_wgnt), 32'h0);
      check($sformatf("b_starve%0d_nrv", k), 32'(b_nrvalid), (k >= 3) ? 32'h2 : 32'h0);
      @(posedge clk);
      #1;
    end
    b_nreq = '0; b_wreq = 1'b0;
    @(negedge clk);
`ifdef LAGD_MEM_ARB_STALL_CNT_EN
    check("b_stall10", 32'(b_stall), 32'd10);
`else
    check("b_stall_tied", 32'(b_stall), 32'd0);
`endif
    check("b_drain10_nrv", 32'(b_nrvalid), 32'h2);
    for (int k = 11; k <= 13; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("b_drain%0d_nrv", k), 32'(b_nrvalid), (k <= 12) ? 32'h2 : 32'h0);
    end
    @(posedge clk);
    #1;

    // B: wide read of 0x12, data returned exactly 3 cycles after the grant
    b_wreq = 1'b1; b_wwe = 1'b0; b_waddr = 10'h12; b_wbe = 4'hF;
    @(negedge clk);
    check("b_wide_gnt", 32'(b_wgnt), 32'h1);
    check("b_wide_ngnt", 32'(b_ngnt), 32'h0);
    check("b_wide_breq", 32'(b_breq), 32'h1);
    check("b_wide_baddr", 32'(b_baddr), 32'h12);
    check("b_wide_bwe", 32'(b_bwe), 32'h0);
    @(posedge clk);
    #1 b_wreq = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      b_brdata = (k == 3) ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
      check($sformatf("b_lat%0d_wrv", k), 32'(b_wrvalid), (k == 3) ? 32'h1 : 32'h0);
      check($sformatf("b_lat%0d_nrv", k), 32'(b_nrvalid), 32'h0);
      if (k == 3) check("b_lat_rdata", b_wrdata, 32'hDEADBEEF);
      @(posedge clk);
      #1;
    end

    // B: reset one cycle after a grant drops the in-flight response
    b_nreq = 4'b0100;
    @(negedge clk);
    check("b_pre_rst_ngnt", 32'(b_ngnt), 32'h4);
    @(posedge clk);
    #1 b_nreq = '0; b_rst_n = 1'b0;
    @(negedge clk);
    check("b_in_rst_nrv", 32'(b_nrvalid), 32'h0);
    @(posedge clk);
    #1 b_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("b_post_rst%0d_nrv", k), 32'(b_nrvalid), 32'h0);
      check($sformatf("b_post_rst%0d_wrv", k), 32'(b_wrvalid), 32'h0);
      @(posedge clk);
      #1;
    end
    b_nreq = 4'hF;
    @(negedge clk);
    check("b_post_rst_first_gnt", 32'(b_ngnt), 32'h1);
    @(posedge clk);
    #1 b_nreq = '0;

    // Randomized run on instance A against the model
    a_rst_n = 1'b0;
    @(posedge clk);
    #1 a_rst_n = 1'b1;
    m_rr = N - 1; m_wait = 0; m_stall = 0; cyc = 0; w_hold = 1'b0;
    for (int p = 0; p < N; p++) n_hold[p] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N; p++) begin
        if (!n_hold[p]) begin
          n_hold[p] = ($urandom_range(0, 99) < 45);
          m_addr[p] = AW'($urandom);
          m_we[p]   = 1'($urandom);
          m_wd[p]   = $urandom;
          m_be[p]   = BW'($urandom);
        end
        a_nreq[p]              = n_hold[p];
        a_nwe[p]               = m_we[p];
        a_naddr[p*AW +: AW]    = m_addr[p];
        a_nwdata[p*DW +: DW]   = m_wd[p];
        a_nbe[p*BW +: BW]      = m_be[p];
      end
      if (!w_hold) begin
        w_hold  = ($urandom_range(0, 99) < 40);
        a_waddr = AW'($urandom);
        a_wwe   = 1'($urandom);
        a_wwdata = $urandom;
        a_wbe   = BW'($urandom);
      end
      a_wreq   = w_hold;
      a_brdata = $urandom;
      @(negedge clk);

      any_n = 1'b0;
      for (int p = 0; p < N; p++) any_n |= n_hold[p];
      exp_w = w_hold && (!any_n || (m_wait == WPW_A));
      exp_n = -1;
      if (!exp_w) begin
        for (int k = 1; k <= N; k++) begin
          if (exp_n < 0 && n_hold[(m_rr + k) % N]) exp_n = (m_rr + k) % N;
        end
      end
      check("rnd_ngnt", 32'(a_ngnt), (exp_n >= 0) ? (32'h1 << exp_n) : 32'h0);
      check("rnd_wgnt", 32'(a_wgnt), 32'(exp_w));
      check("rnd_breq", 32'(a_breq), 32'(exp_w || exp_n >= 0));
      if (exp_w) begin
        check("rnd_w_addr", 32'(a_baddr), 32'(a_waddr));
        check("rnd_w_we", 32'(a_bwe), 32'(a_wwe));
        check("rnd_w_wdata", a_bwdata, a_wwdata);
        check("rnd_w_be", 32'(a_bbe), 32'(a_wbe));
      end else if (exp_n >= 0) begin
        check("rnd_n_addr", 32'(a_baddr), 32'(m_addr[exp_n]));
        check("rnd_n_we", 32'(a_bwe), 32'(m_we[exp_n]));
        check("rnd_n_wdata", a_bwdata, m_wd[exp_n]);
        check("rnd_n_be", 32'(a_bbe), 32'(m_be[exp_n]));
      end

      exp_nrv = '0; exp_wrv = 1'b0;
      while (rq.size() > 0 && rq[0].due == cyc) begin
        if (rq[0].wide) exp_wrv = 1'b1;
        else exp_nrv[rq[0].idx] = 1'b1;
        void'(rq.pop_front());
      end
      check("rnd_nrv", 32'(a_nrvalid), 32'(exp_nrv));
      check("rnd_wrv", 32'(a_wrvalid), 32'(exp_wrv));
      if (exp_nrv != 0) check("rnd_nrdata", a_nrdata, a_brdata);
      if (exp_wrv) check("rnd_wrdata", a_wrdata, a_brdata);

`ifdef LAGD_MEM_ARB_STALL_CNT_EN
      check("rnd_stall", 32'(a_stall), m_stall);
`else
      check("rnd_stall", 32'(a_stall), 32'h0);
`endif
      stalled = w_hold && !exp_w;
      for (int p = 0; p < N; p++) if (n_hold[p] && p != exp_n) stalled = 1'b1;
      if (stalled && m_stall < 32'hFFFF) m_stall++;

      if (exp_w) m_wait = 0;
      else if (w_hold) m_wait = (m_wait < WPW_A) ? m_wait + 1 : WPW_A;
      else m_wait = 0;
      if (exp_n >= 0) begin
        m_rr = exp_n;
        n_hold[exp_n] = 1'b0;
        rq.push_back('{due: cyc + LAT_A, wide: 1'b0, idx: exp_n});
      end
      if (exp_w) begin
        w_hold = 1'b0;
        rq.push_back('{due: cyc + LAT_A, wide: 1'b1, idx: 0});
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    a_nreq = '0; a_wreq = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
